// File: rtl/tbuf_pkg.sv
// ============================================================================
// Module  : tbuf_pkg
// Brief   : Shared types and helpers for the tbuf long-line bus arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package tbuf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } tbuf_arb_state_t;

    // Modular add for index arithmetic; both operands are already < n.
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin search: first set request at or above
//           ptr, wrapping at N.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_picker
    import tbuf_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int c_id_w = $clog2(N);

    logic [2*N-1:0]    w_req2;
    logic [N-1:0]      w_rot;
    logic [c_id_w-1:0] w_off;
    logic              w_any;

    // Rotating the doubled vector puts the request at ptr into bit 0.
    assign w_req2 = {req, req};
    assign w_rot  = N'(w_req2 >> ptr);

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_off = c_id_w'(k);
            end
        end
    end

    assign found = w_any;
    assign idx   = c_id_w'(wrap_add(32'(ptr), 32'(w_off), N));

endmodule

`default_nettype wire

// File: rtl/tbuf_bus_arbiter.sv
// ============================================================================
// Module  : tbuf_bus_arbiter
// Brief   : Round-robin output-enable generator for N tbuf drivers on one
//           long line, with hold cap and enforced turnaround gap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tbuf_bus_arbiter
    import tbuf_pkg::*;
#(
    parameter int N           = 4,
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 bus_en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         oe,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 bus_busy
);

    localparam int c_id_w   = $clog2(N);
    localparam int c_hold_w = $clog2(MAX_HOLD + 1);
    localparam int c_turn_w = $clog2(TURN_CYCLES + 1);

    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD);
    localparam logic [c_turn_w-1:0] c_turn_max = c_turn_w'(TURN_CYCLES);
    localparam logic [N-1:0]        c_oe_one   = {{(N-1){1'b0}}, 1'b1};

    tbuf_arb_state_t     r_state;
    logic [c_id_w-1:0]   r_rr_ptr;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [c_turn_w-1:0] r_turn_cnt;
    logic [N-1:0]        r_oe;
    logic                r_grant_valid;
    logic [c_id_w-1:0]   r_grant_id;
    logic                r_bus_busy;

    logic                w_found;
    logic [c_id_w-1:0]   w_idx;
    logic                w_release;
    logic [c_id_w-1:0]   w_next_ptr;

    rr_picker #(
        .N     (N)
    ) u_rr_picker (
        .req   (req),
        .ptr   (r_rr_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    assign w_release  = !req[r_grant_id] || (r_hold_cnt == c_hold_max) || !bus_en;
    assign w_next_ptr = c_id_w'(wrap_add(32'(r_grant_id), 32'd1, N));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            // The line is treated as undriven at reset, so no turnaround.
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_hold_cnt    <= '0;
            r_turn_cnt    <= '0;
            r_oe          <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_bus_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus_en && w_found) begin
                        r_state       <= DRIVE;
                        r_hold_cnt    <= c_hold_w'(1);
                        r_oe          <= c_oe_one << w_idx;
                        r_grant_valid <= 1'b1;
                        r_grant_id    <= w_idx;
                        r_bus_busy    <= 1'b1;
                    end
                end

                DRIVE: begin
                    if (w_release) begin
                        r_state       <= TURN;
                        r_rr_ptr      <= w_next_ptr;
                        r_turn_cnt    <= c_turn_w'(1);
                        r_oe          <= '0;
                        r_grant_valid <= 1'b0;
                        r_grant_id    <= '0;
                    end else if (r_hold_cnt != c_hold_max) begin
                        r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
                    end
                end

                TURN: begin
                    if (r_turn_cnt == c_turn_max) begin
                        // Last gap cycle: requests raised during TURN compete here.
                        if (bus_en && w_found) begin
                            r_state       <= DRIVE;
                            r_hold_cnt    <= c_hold_w'(1);
                            r_oe          <= c_oe_one << w_idx;
                            r_grant_valid <= 1'b1;
                            r_grant_id    <= w_idx;
                        end else begin
                            r_state    <= IDLE;
                            r_bus_busy <= 1'b0;
                        end
                    end else begin
                        r_turn_cnt <= r_turn_cnt + c_turn_w'(1);
                    end
                end

                default: begin
                    r_state       <= IDLE;
                    r_oe          <= '0;
                    r_grant_valid <= 1'b0;
                    r_grant_id    <= '0;
                    r_bus_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign oe          = r_oe;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign bus_busy    = r_bus_busy;

endmodule

`default_nettype wire
